pipe_stage_skid_reg: RTL and testbench

//  Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid_reg.sv | 129 ++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline register with valid/ready on both sides and a 2-entry skid buffer.
// Handshake outputs depend only on held state, freeze and flush, never on the opposite side.
module pipe_stage_skid_reg #(
  parameter int                 WIDTH       = 64,
  parameter logic [WIDTH-1:0]   FLUSH_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               push_s, pop_s, stall_evt_s;

  // Handshake gating and status decode
  always_comb begin
    in_ready    = !freeze && !flush && (state_q != ST_FULL);
    out_valid   = !freeze && !flush && (state_q != ST_EMPTY);
    push_s      = in_valid && in_ready;
    pop_s       = out_valid && out_ready;
    out_data    = main_q;
    stall_count = stall_q;
    stall_evt_s = freeze || ((state_q != ST_EMPTY) && !out_ready);
    case (state_q)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  // Next state of the entry pair: freeze wins over flush, flush over normal traffic
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (freeze) begin
      state_d = state_q;
    end else if (flush) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VALUE;
      skid_d  = FLUSH_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            main_d = in_data;
          end else if (push_s) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // The skid entry only ever reaches the output by moving into main
          if (pop_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = FLUSH_VALUE;
          skid_d  = FLUSH_VALUE;
        end
      endcase
    end
  end

  // Saturating stall counter, survives flush
  always_comb begin
    if (stall_evt_s && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State and entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= FLUSH_VALUE;
      skid_q  <= FLUSH_VALUE;
      stall_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: reset, streaming, backpressure, flush, freeze and stall saturation.
module tb_pipe_stage_skid_reg;

  logic        clk;
  logic        rst;
  logic        freeze, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_count;

  logic        b_freeze, b_flush, b_in_valid, b_out_ready;
  logic        b_in_ready, b_out_valid;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_occupancy;
  logic [1:0]  b_stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  pipe_stage_skid_reg #(.WIDTH(64), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .freeze(b_freeze), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy), .stall_count(b_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = 64'hAB; out_ready = 1'b0;
    b_freeze = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 64'h0; b_out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'h0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got out_valid=%b in_ready=%b out_data=%h occ=%0d, want 0 1 0 0",
               out_valid, in_ready, out_data, occupancy);
    end
    #2 rst = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++;
    if (occupancy !== 2'd0 || stall_count !== 16'd0 || b_stall_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_no_capture: got occ=%0d stall=%0d b_stall=%0d, want 0 0 0",
               occupancy, stall_count, b_stall_count);
    end
  endtask

  task automatic test_streaming();
    logic [63:0] vals [3];
    vals[0] = 64'h1; vals[1] = 64'h2; vals[2] = 64'h3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_%0d: got valid=%b data=%h occ=%0d, want 1 %h 1",
                 i, out_valid, out_data, occupancy, vals[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stream_drain: got occ=%0d valid=%b stall=%0d, want 0 0 0",
               occupancy, out_valid, stall_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h10;
    tick();
    in_data = 64'h11;
    tick();
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'h10) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d in_ready=%b data=%h, want 2 0 10", occupancy, in_ready, out_data);
    end
    in_data = 64'h12;
    tick();
    n_checks++;
    if (occupancy !== 2'd2 || out_data !== 64'h10 || stall_count !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_hold: got occ=%0d data=%h stall=%0d, want 2 10 2", occupancy, out_data, stall_count);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h10) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%b data=%h, want 1 10", out_valid, out_data);
    end
    tick();
    n_checks++;
    if (out_data !== 64'h11 || in_ready !== 1'b1 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got data=%h in_ready=%b occ=%0d valid=%b, want 11 1 1 1",
               out_data, in_ready, occupancy, out_valid);
    end
    tick();
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got occ=%0d valid=%b, want 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h20;
    tick();
    in_data = 64'h21;
    tick();
    flush = 1'b1; in_data = 64'h99;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_gate: got in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 2'd0 || out_data !== 64'h0 || out_valid !== 1'b0 || stall_count !== 16'd4) begin
      n_fail++;
      $display("FAIL flush_full: got occ=%0d data=%h valid=%b stall=%0d, want 0 0 0 4",
               occupancy, out_data, out_valid, stall_count);
    end
  endtask

  task automatic test_freeze();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h55;
    tick();
    in_valid = 1'b0; freeze = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_gate: got out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
    end
    tick(); tick(); tick();
    n_checks++;
    if (occupancy !== 2'd1 || out_data !== 64'h55 || stall_count !== 16'd7) begin
      n_fail++;
      $display("FAIL freeze_hold: got occ=%0d data=%h stall=%0d, want 1 55 7", occupancy, out_data, stall_count);
    end
    freeze = 1'b0; flush = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h55) begin
      n_fail++;
      $display("FAIL freeze_release: got valid=%b data=%h, want 1 55", out_valid, out_data);
    end
    tick();
    n_checks++;
    if (occupancy !== 2'd0 || stall_count !== 16'd7) begin
      n_fail++;
      $display("FAIL freeze_drain: got occ=%0d stall=%0d, want 0 7", occupancy, stall_count);
    end
  endtask

  task automatic test_stall_saturate();
    logic [1:0] exp [6];
    exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd3; exp[4] = 2'd3; exp[5] = 2'd3;
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'h7;
    tick();
    b_in_valid = 1'b0;
    n_checks++;
    if (b_stall_count !== 2'd0 || b_occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL sat_start: got stall=%0d occ=%0d, want 0 1", b_stall_count, b_occupancy);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (b_stall_count !== exp[i]) begin
        n_fail++;
        $display("FAIL sat_%0d: got stall=%0d, want %0d", i, b_stall_count, exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    b_in_valid = 1'b1; b_in_data = 64'h8;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (b_occupancy !== 2'd0 || b_stall_count !== 2'd0 || b_out_data !== 64'h0 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got occ=%0d stall=%0d data=%h valid=%b, want 0 0 0 0",
               b_occupancy, b_stall_count, b_out_data, b_out_valid);
    end
    #1 rst = 1'b0; b_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_freeze();
    test_stall_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
